wb_router: RTL and testbench
============================

WB_ROUTER -- requirements
Module: wb_router

Interface
REQ-001 SHALL import types:: for NUM_Threads (default 4), NUM_ALUs (default 4).
REQ-002 Parameter FLUSH_CYCLES, default 2: cycles of writeback suppression after a taken jump.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 alu_valid[NUM_ALUs]  input  1  ALU slot carries a result this cycle.
REQ-006 alu_tid[NUM_ALUs]  input  3  owning thread (the dispatch_threads value used for that ALU).
REQ-007 alu_rd_addr / alu_rd_data / alu_rd_wen[NUM_ALUs]  input  5/32/1  ALU writeback result.
REQ-008 alu_jump_addr / alu_jump_en / alu_hold[NUM_ALUs]  input  32/1/1  ALU control result.
REQ-009 rd_addr / rd_data / rd_wen2reg[NUM_Threads]  output  5/32/1  per-thread register-file write.
REQ-010 jump_addr2ctrl / jump_en2ctrl / hold2ctrl[NUM_Threads]  output  32/1/1  per-thread ctrl request.
REQ-011 flushing[NUM_Threads]  output  1  thread is in post-jump suppression window.
REQ-012 conflict[NUM_Threads]  output  1  two or more ALUs targeted thread last cycle (see REQ-027).

Function
REQ-013 Slot a SHALL be live iff alu_valid[a]=1 and alu_tid[a]<NUM_Threads; other slots are dropped silently.
REQ-014 Per thread t, winner SHALL be lowest-index live slot with alu_tid=t; no winner -> all thread outputs 0.
REQ-015 All data/control outputs SHALL be registered: input at edge N visible after edge N, latency exactly 1 cycle.
REQ-016 rd_addr/rd_data/jump_addr2ctrl SHALL carry winner values regardless of gating; zero when no winner.
REQ-017 rd_wen2reg[t] SHALL = winner rd_wen AND rd_addr!=0 AND NOT flush_active[t].
REQ-018 jump_en2ctrl[t] and hold2ctrl[t] SHALL = winner value AND NOT flush_active[t].
REQ-019 Per-thread counter fcnt[t], width clog2(FLUSH_CYCLES+1); flush_active[t] = fcnt[t]!=0; flushing[t] = flush_active[t].
REQ-020 Counter states: IDLE (0) -> LOAD on accepted (ungated) jump: fcnt=FLUSH_CYCLES next edge; COUNT: decrement by 1 per edge to 0.
REQ-021 A jump arriving while flush_active SHALL be suppressed and SHALL NOT reload the counter.
REQ-022 Accepted jump SHALL still emit rd_wen2reg for its own link write (JAL/JALR rd) in the same cycle.
REQ-023 FLUSH_CYCLES=0 SHALL disable suppression (fcnt constant 0).
REQ-024 Threads SHALL be fully independent; simultaneous jumps on all threads each load own counter.

Reset
REQ-025 rst_n low SHALL asynchronously force every output and every fcnt to 0, including mid-flush.
REQ-026 First result after rst_n deassertion SHALL be treated as IDLE (no suppression).

Configuration
REQ-027 Macro WB_CONFLICT_CHK_EN defined: conflict[t] registered, =1 for one cycle when >=2 live slots named t; 8-bit saturating counter conflict_cnt (output, 8 bits) increments per conflicting thread-cycle, reset 0.
REQ-028 Macro undefined: conflict[t] tied 0, conflict_cnt absent; routing per REQ-014 unchanged.

Structure
REQ-029 NUM_Threads, NUM_ALUs, thread-id width (3) SHALL live in package types; a wb_result_t struct (rd_addr, rd_data, rd_wen, jump_addr, jump_en, hold) SHALL be added there.
REQ-030 One sub-module wb_flush_ctr (single thread counter, REQ-019..REQ-023) SHALL be instantiated NUM_Threads times.

Verification
REQ-031 ALU0 tid=2 rd_addr=5 data=0xDEADBEEF wen=1 -> next cycle rd_wen2reg[2]=1, rd_addr[2]=5, rd_data[2]=0xDEADBEEF; other threads 0.
REQ-032 ALU1 and ALU3 both tid=1, data 0x11/0x33 -> rd_data[1]=0x11; conflict[1]=1, conflict_cnt=1 (macro on).
REQ-033 Thread 0 jump_en=1 addr=0x100 -> jump_en2ctrl[0]=1; next two results for thread 0 (wen=1, jump_en=1) give rd_wen2reg[0]=0, jump_en2ctrl[0]=0; third result writes.
REQ-034 rd_addr=0 wen=1 -> rd_wen2reg=0; alu_tid=5 valid=1 -> no thread output.
REQ-035 rst_n pulsed low while fcnt[3]=1 -> all outputs 0 immediately; next thread-3 write after release accepted.

Source files
------------

// File: rtl/wb_router_pkg.sv
// Shared thread/ALU sizing and the per-slot writeback record for wb_router.
package types;
  localparam int NUM_Threads = 4;
  localparam int NUM_ALUs    = 4;
  localparam int TID_W       = 3;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_wen;
    logic [31:0] jump_addr;
    logic        jump_en;
    logic        hold;
  } wb_result_t;
endpackage

// File: rtl/wb_router_flush_ctr.sv
// Per-thread post-jump suppression counter: loads FLUSH_CYCLES on an accepted
// jump, then counts down to zero; FLUSH_CYCLES=0 disables suppression.
module wb_flush_ctr #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic jump_accept,
  output logic flush_active
);
  generate
    if (FLUSH_CYCLES == 0) begin : g_off
      assign flush_active = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(FLUSH_CYCLES + 1);
      logic [W-1:0] fcnt_reg;

      // A jump seen while counting is already suppressed upstream, so the
      // load branch is only reachable from zero and never restarts a window.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fcnt_reg <= '0;
        end else if (fcnt_reg != '0) begin
          fcnt_reg <= fcnt_reg - W'(1);
        end else if (jump_accept) begin
          fcnt_reg <= W'(FLUSH_CYCLES);
        end
      end

      assign flush_active = (fcnt_reg != '0);
    end
  endgenerate
endmodule

// File: rtl/wb_router.sv
// Routes ALU writeback/control results to per-thread outputs (lowest ALU wins),
// with post-jump suppression. Optional conflict tracking: WB_CONFLICT_CHK_EN.
module wb_router
  import types::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid      [NUM_ALUs],
  input  logic [TID_W-1:0]  alu_tid        [NUM_ALUs],
  input  logic [4:0]        alu_rd_addr    [NUM_ALUs],
  input  logic [31:0]       alu_rd_data    [NUM_ALUs],
  input  logic              alu_rd_wen     [NUM_ALUs],
  input  logic [31:0]       alu_jump_addr  [NUM_ALUs],
  input  logic              alu_jump_en    [NUM_ALUs],
  input  logic              alu_hold       [NUM_ALUs],
  output logic [4:0]        rd_addr        [NUM_Threads],
  output logic [31:0]       rd_data        [NUM_Threads],
  output logic              rd_wen2reg     [NUM_Threads],
  output logic [31:0]       jump_addr2ctrl [NUM_Threads],
  output logic              jump_en2ctrl   [NUM_Threads],
  output logic              hold2ctrl      [NUM_Threads],
  output logic              flushing       [NUM_Threads],
  output logic              conflict       [NUM_Threads]
`ifdef WB_CONFLICT_CHK_EN
  ,
  output logic [7:0]        conflict_cnt
`endif
);
  wb_result_t           alu_res [NUM_ALUs];
  logic [NUM_ALUs-1:0]  live;
`ifdef WB_CONFLICT_CHK_EN
  logic [NUM_Threads-1:0] multi_vec;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ALUs; gi++) begin : g_slot
      assign live[gi]    = alu_valid[gi] && (int'(alu_tid[gi]) < NUM_Threads);
      assign alu_res[gi] = '{rd_addr:   alu_rd_addr[gi],
                             rd_data:   alu_rd_data[gi],
                             rd_wen:    alu_rd_wen[gi],
                             jump_addr: alu_jump_addr[gi],
                             jump_en:   alu_jump_en[gi],
                             hold:      alu_hold[gi]};
    end

    for (gi = 0; gi < NUM_Threads; gi++) begin : g_thread
      wb_result_t win;
      wb_result_t res_reg;
      logic       hit;
      logic       flush_active;
      logic       accept_jump;
`ifdef WB_CONFLICT_CHK_EN
      logic       multi;
      logic       conflict_reg;
`endif

      always_comb begin
        win = '0;
        hit = 1'b0;
`ifdef WB_CONFLICT_CHK_EN
        multi = 1'b0;
`endif
        for (int a = 0; a < NUM_ALUs; a++) begin
          if (live[a] && (int'(alu_tid[a]) == gi)) begin
`ifdef WB_CONFLICT_CHK_EN
            if (hit) multi = 1'b1;
`endif
            if (!hit) win = alu_res[a];
            hit = 1'b1;
          end
        end
      end

      assign accept_jump = win.jump_en && !flush_active;

      // Data/address fields pass through ungated; only the enables are masked.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_reg <= '0;
        end else begin
          res_reg <= '{rd_addr:   win.rd_addr,
                       rd_data:   win.rd_data,
                       rd_wen:    win.rd_wen && (win.rd_addr != 5'd0) && !flush_active,
                       jump_addr: win.jump_addr,
                       jump_en:   accept_jump,
                       hold:      win.hold && !flush_active};
        end
      end

      wb_flush_ctr #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush_ctr (
        .clk          (clk),
        .rst_n        (rst_n),
        .jump_accept  (accept_jump),
        .flush_active (flush_active)
      );

      assign rd_addr[gi]        = res_reg.rd_addr;
      assign rd_data[gi]        = res_reg.rd_data;
      assign rd_wen2reg[gi]     = res_reg.rd_wen;
      assign jump_addr2ctrl[gi] = res_reg.jump_addr;
      assign jump_en2ctrl[gi]   = res_reg.jump_en;
      assign hold2ctrl[gi]      = res_reg.hold;
      assign flushing[gi]       = flush_active;

`ifdef WB_CONFLICT_CHK_EN
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conflict_reg <= 1'b0;
        else        conflict_reg <= multi;
      end
      assign multi_vec[gi] = multi;
      assign conflict[gi]  = conflict_reg;
`else
      assign conflict[gi]  = 1'b0;
`endif
    end
  endgenerate

`ifdef WB_CONFLICT_CHK_EN
  logic [7:0] conflict_cnt_reg;
  logic [8:0] cnt_sum;

  // Several threads may conflict in one cycle; each counts once, saturating.
  always_comb cnt_sum = {1'b0, conflict_cnt_reg} + 9'($countones(multi_vec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_cnt_reg <= 8'd0;
    else        conflict_cnt_reg <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  assign conflict_cnt = conflict_cnt_reg;
`endif
endmodule

// File: tb/tb_wb_router.sv
// Directed-vector bench for wb_router (FLUSH_CYCLES=2); conflict checks follow WB_CONFLICT_CHK_EN.
module tb_wb_router;
  import types::*;

`ifdef WB_CONFLICT_CHK_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid      [NUM_ALUs];
  logic [2:0]  alu_tid        [NUM_ALUs];
  logic [4:0]  alu_rd_addr    [NUM_ALUs];
  logic [31:0] alu_rd_data    [NUM_ALUs];
  logic        alu_rd_wen     [NUM_ALUs];
  logic [31:0] alu_jump_addr  [NUM_ALUs];
  logic        alu_jump_en    [NUM_ALUs];
  logic        alu_hold       [NUM_ALUs];
  logic [4:0]  rd_addr        [NUM_Threads];
  logic [31:0] rd_data        [NUM_Threads];
  logic        rd_wen2reg     [NUM_Threads];
  logic [31:0] jump_addr2ctrl [NUM_Threads];
  logic        jump_en2ctrl   [NUM_Threads];
  logic        hold2ctrl      [NUM_Threads];
  logic        flushing       [NUM_Threads];
  logic        conflict       [NUM_Threads];
`ifdef WB_CONFLICT_CHK_EN
  logic [7:0]  conflict_cnt;
`endif

  always #5 clk = ~clk;

  wb_router #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_tid(alu_tid), .alu_rd_addr(alu_rd_addr),
    .alu_rd_data(alu_rd_data), .alu_rd_wen(alu_rd_wen), .alu_jump_addr(alu_jump_addr),
    .alu_jump_en(alu_jump_en), .alu_hold(alu_hold),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_wen2reg(rd_wen2reg),
    .jump_addr2ctrl(jump_addr2ctrl), .jump_en2ctrl(jump_en2ctrl), .hold2ctrl(hold2ctrl),
    .flushing(flushing), .conflict(conflict)
`ifdef WB_CONFLICT_CHK_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  logic [3:0]       o_wen, o_jen, o_hold, o_flush, o_conf;
  logic [3:0][4:0]  o_ra;
  logic [3:0][31:0] o_dat, o_jad;
  always_comb begin
    for (int t = 0; t < 4; t++) begin
      o_wen[t]   = rd_wen2reg[t];
      o_jen[t]   = jump_en2ctrl[t];
      o_hold[t]  = hold2ctrl[t];
      o_flush[t] = flushing[t];
      o_conf[t]  = conflict[t];
      o_ra[t]    = rd_addr[t];
      o_dat[t]   = rd_data[t];
      o_jad[t]   = jump_addr2ctrl[t];
    end
  end

  typedef struct packed {
    logic [3:0]       valid;
    logic [3:0][2:0]  tid;
    logic [3:0][4:0]  ra;
    logic [3:0][31:0] dat;
    logic [3:0]       wen, jen, hold;
    logic [3:0]       e_wen, e_jen, e_hold, e_flush, e_conf;
    logic [3:0][4:0]  e_ra;
    logic [3:0][31:0] e_dat;
  } vec_t;

  localparam int NV = 10;
  vec_t tv [NV];
  int   pass_cnt = 0;
  int   total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic slot(input int r, input int a, input int tid, input int ra,
                      input logic [31:0] dat, input bit wen, input bit jen, input bit hold);
    tv[r].valid[a] = 1'b1;
    tv[r].tid[a]   = 3'(tid);
    tv[r].ra[a]    = 5'(ra);
    tv[r].dat[a]   = dat;
    tv[r].wen[a]   = wen;
    tv[r].jen[a]   = jen;
    tv[r].hold[a]  = hold;
  endtask

  task automatic expt(input int r, input int t, input int ra, input logic [31:0] dat,
                      input bit wen, input bit jen, input bit hold);
    tv[r].e_ra[t]   = 5'(ra);
    tv[r].e_dat[t]  = dat;
    tv[r].e_wen[t]  = wen;
    tv[r].e_jen[t]  = jen;
    tv[r].e_hold[t] = hold;
  endtask

  task automatic drive(input vec_t v);
    for (int a = 0; a < 4; a++) begin
      alu_valid[a]     = v.valid[a];
      alu_tid[a]       = v.tid[a];
      alu_rd_addr[a]   = v.ra[a];
      alu_rd_data[a]   = v.dat[a];
      alu_rd_wen[a]    = v.wen[a];
      alu_jump_en[a]   = v.jen[a];
      alu_hold[a]      = v.hold[a];
      alu_jump_addr[a] = 32'h1000 + 32'(a);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t sv;

  initial begin
    for (int r = 0; r < NV; r++) tv[r] = '0;
    // r0: single write to thread 2
    slot(0, 0, 2, 5, 32'hDEADBEEF, 1, 0, 0);
    expt(0, 2, 5, 32'hDEADBEEF, 1, 0, 0);
    // r1: two ALUs target thread 1, lowest index wins
    slot(1, 1, 1, 3, 32'h11, 1, 0, 0);
    slot(1, 3, 1, 7, 32'h33, 1, 0, 0);
    expt(1, 1, 3, 32'h11, 1, 0, 0);
    tv[1].e_conf = CONF_EN ? 4'b0010 : 4'b0000;
    // r2: x0 write masked, out-of-range tid dropped, invalid slot ignored
    slot(2, 0, 0, 0, 32'h55, 1, 0, 0);
    slot(2, 1, 5, 9, 32'h66, 1, 1, 1);
    slot(2, 2, 3, 9, 32'h99, 1, 1, 1);
    tv[2].valid[2] = 1'b0;
    expt(2, 0, 0, 32'h55, 0, 0, 0);
    // r3: hold on thread 3, conflict on thread 1
    slot(3, 0, 1, 1, 32'h1, 1, 0, 0);
    slot(3, 1, 1, 2, 32'h2, 1, 0, 0);
    slot(3, 2, 3, 4, 32'h44, 0, 0, 1);
    expt(3, 1, 1, 32'h1, 1, 0, 0);
    expt(3, 3, 4, 32'h44, 0, 0, 1);
    tv[3].e_conf = CONF_EN ? 4'b0010 : 4'b0000;
    // r4..r7: every thread jumps each cycle; accept, suppress x2, accept again
    for (int r = 4; r < 8; r++)
      for (int a = 0; a < 4; a++) begin
        slot(r, a, a, a + 1, 32'h10 + 32'(a), 1, 1, 0);
        expt(r, a, a + 1, 32'h10 + 32'(a), (r == 4 || r == 7), (r == 4 || r == 7), 0);
      end
    tv[4].e_flush = 4'b1111;
    tv[5].e_flush = 4'b1111;
    tv[6].e_flush = 4'b0000;
    tv[7].e_flush = 4'b1111;
    // r8, r9: idle while the last window drains
    tv[8].e_flush = 4'b1111;
    tv[9].e_flush = 4'b0000;

    // Reset state
    sv = '0;
    drive(sv);
    rst_n = 1'b0;
    step();
    chk("rst.rd_wen", o_wen, 0);
    chk("rst.rd_data", o_dat, 0);
    chk("rst.jump_en", o_jen, 0);
    chk("rst.flushing", o_flush, 0);
`ifdef WB_CONFLICT_CHK_EN
    chk("rst.conflict_cnt", conflict_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int r = 0; r < NV; r++) begin
      drive(tv[r]);
      step();
      chk($sformatf("v%0d.rd_wen", r),   o_wen,   tv[r].e_wen);
      chk($sformatf("v%0d.jump_en", r),  o_jen,   tv[r].e_jen);
      chk($sformatf("v%0d.hold", r),     o_hold,  tv[r].e_hold);
      chk($sformatf("v%0d.flushing", r), o_flush, tv[r].e_flush);
      chk($sformatf("v%0d.conflict", r), o_conf,  tv[r].e_conf);
      chk($sformatf("v%0d.rd_addr", r),  o_ra,    tv[r].e_ra);
      chk($sformatf("v%0d.rd_data", r),  o_dat,   tv[r].e_dat);
      $display("vec %0d: wen=%b jen=%b hold=%b flush=%b conf=%b", r, o_wen, o_jen, o_hold, o_flush, o_conf);
    end
`ifdef WB_CONFLICT_CHK_EN
    chk("table.conflict_cnt", conflict_cnt, 8'd2);
`endif

    // Thread 0 jump, two suppressed results (link write still emitted with the jump), third accepted
    sv = '0;
    sv.valid[0] = 1'b1; sv.ra[0] = 5'd1; sv.dat[0] = 32'hA0;
    sv.wen[0] = 1'b1; sv.jen[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(sv);
      alu_jump_addr[0] = 32'h100;
      step();
      chk($sformatf("jmp%0d.jump_en0", k), o_jen[0], (k == 0 || k == 3));
      chk($sformatf("jmp%0d.rd_wen0", k),  o_wen[0], (k == 0 || k == 3));
      chk($sformatf("jmp%0d.jump_addr0", k), o_jad[0], 32'h100);
      $display("jump seq %0d: jen0=%b wen0=%b flush0=%b", k, o_jen[0], o_wen[0], o_flush[0]);
    end
    sv = '0;
    drive(sv);
    step();
    step();
    chk("jmp.drain.flushing", o_flush, 0);
    chk("jmp.drain.jump_addr0", o_jad[0], 0);

    // Reset asserted mid-flush on thread 3, then a write right after release
    sv = '0;
    sv.valid[0] = 1'b1; sv.tid[0] = 3'd3; sv.ra[0] = 5'd2; sv.dat[0] = 32'h30;
    sv.wen[0] = 1'b1; sv.jen[0] = 1'b1;
    drive(sv);
    step();
    chk("rstmid.jump_en3", o_jen[3], 1'b1);
    sv.jen[0] = 1'b0; sv.ra[0] = 5'd6; sv.dat[0] = 32'h77;
    drive(sv);
    step();
    chk("rstmid.pre.flushing3", o_flush[3], 1'b1);
    chk("rstmid.pre.rd_data3", o_dat[3], 32'h77);
    chk("rstmid.pre.rd_wen3", o_wen[3], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.async.rd_data", o_dat, 0);
    chk("rstmid.async.rd_addr", o_ra, 0);
    chk("rstmid.async.flushing", o_flush, 0);
    $display("async reset: data3=%0h flush=%b", o_dat[3], o_flush);
    #2;
    rst_n = 1'b1;
    sv.dat[0] = 32'h88;
    drive(sv);
    step();
    chk("rstmid.post.rd_wen3", o_wen[3], 1'b1);
    chk("rstmid.post.rd_data3", o_dat[3], 32'h88);
    $display("post reset write: wen3=%b data3=%0h", o_wen[3], o_dat[3]);

`ifdef WB_CONFLICT_CHK_EN
    // Counter from reset: one conflict, then saturation with two conflicts per cycle
    sv = '0;
    sv.valid = 4'b1010; sv.tid[1] = 3'd1; sv.tid[3] = 3'd1;
    sv.dat[1] = 32'h11; sv.dat[3] = 32'h33; sv.wen = 4'b1010; sv.ra[1] = 5'd3; sv.ra[3] = 5'd3;
    drive(sv);
    step();
    chk("cnt.first.conflict", o_conf, 4'b0010);
    chk("cnt.first.rd_data1", o_dat[1], 32'h11);
    chk("cnt.first.conflict_cnt", conflict_cnt, 8'd1);
    sv = '0;
    sv.valid = 4'b1111; sv.tid[2] = 3'd1; sv.tid[3] = 3'd1;
    drive(sv);
    for (int k = 0; k < 130; k++) step();
    chk("cnt.sat.conflict", o_conf, 4'b0011);
    chk("cnt.sat.conflict_cnt", conflict_cnt, 8'hFF);
    $display("conflict count after saturation: %0d", conflict_cnt);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
